// File: rtl/sd_resp_collector.sv
// -----------------------------------------------------------------------------
// sd_resp_collector
//
// Purpose: after a command frame has gone out, clocks 0xFF poll bytes through
// the SPI byte engine and collects the card's SPI-mode response. Skips NCR
// filler bytes (MSB=1), captures R1 and, for R3/R7, the four trailing bytes.
// Reports completion/timeout to the command sequencer.
//
// Optional feature macro: SD_RESP_BUSYWAIT_EN
//   defined   : R1B=1 adds an R1b busy-wait phase (poll until a non-zero byte,
//               at most BUSY_MAX zero bytes).
//   undefined : R1B is ignored and no busy phase exists.
//
// Ports:
//   CLOCK50   in   1   system clock, rising edge
//   RESET     in   1   asynchronous reset, active low
//   START     in   1   arm pulse, ignored while busy
//   LONG      in   1   with START: expect 4 extra bytes (R3/R7)
//   R1B       in   1   with START: R1b busy phase follows
//   POLL_STB  out  1   request one dummy byte from the SPI engine
//   POLL_DATA out  8   dummy byte, always 8'hFF
//   POLL_ACK  in   1   SPI engine accepted the poll byte
//   RX_STB    in   1   received byte valid
//   RX_DATA   in   8   received byte
//   RX_ACK    out  1   pulse, cycle after a consumed RX_STB
//   BUSY      out  1   transaction in progress
//   DONE      out  1   completion pulse
//   TIMEOUT   out  1   valid with DONE: no R1 / busy never released
//   R1        out  8   captured R1 byte
//   R7        out  32  captured trailing bytes, MSB first
// -----------------------------------------------------------------------------
module sd_resp_collector #(
    parameter int unsigned NCR_MAX  = 8,
    parameter int unsigned BUSY_MAX = 255
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        START,
    input  logic        LONG,
    input  logic        R1B,
    output logic        POLL_STB,
    output logic [7:0]  POLL_DATA,
    input  logic        POLL_ACK,
    input  logic        RX_STB,
    input  logic [7:0]  RX_DATA,
    output logic        RX_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        TIMEOUT,
    output logic [7:0]  R1,
    output logic [31:0] R7
);

    // Counter also counts the 4 data bytes, so never narrower than that needs.
    localparam int unsigned CNT_MAX0 = (NCR_MAX > BUSY_MAX) ? NCR_MAX : BUSY_MAX;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > 4) ? CNT_MAX0 : 4;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StPoll, StWaitRx, StFin} state_t;
    // Which part of the response the next received byte belongs to.
    typedef enum logic [1:0] {PhR1, PhData, PhBusy} phase_t;

    state_t        r_state, w_state_nxt;
    phase_t        r_phase, w_phase_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]    r_r1, w_r1_nxt;
    logic [31:0]   r_r7, w_r7_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          r_long, w_long_nxt;
    logic          r_rx_ack, w_rx_ack_nxt;

`ifdef SD_RESP_BUSYWAIT_EN
    logic          r_r1b, w_r1b_nxt;
`else
    logic          w_unused_r1b;
    assign w_unused_r1b = R1B;
`endif

    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            r_state   <= StIdle;
            r_phase   <= PhR1;
            r_cnt     <= '0;
            r_r1      <= 8'hFF;
            r_r7      <= '0;
            r_timeout <= 1'b0;
            r_long    <= 1'b0;
            r_rx_ack  <= 1'b0;
`ifdef SD_RESP_BUSYWAIT_EN
            r_r1b     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_cnt     <= w_cnt_nxt;
            r_r1      <= w_r1_nxt;
            r_r7      <= w_r7_nxt;
            r_timeout <= w_timeout_nxt;
            r_long    <= w_long_nxt;
            r_rx_ack  <= w_rx_ack_nxt;
`ifdef SD_RESP_BUSYWAIT_EN
            r_r1b     <= w_r1b_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_cnt_nxt     = r_cnt;
        w_r1_nxt      = r_r1;
        w_r7_nxt      = r_r7;
        w_timeout_nxt = r_timeout;
        w_long_nxt    = r_long;
        w_rx_ack_nxt  = 1'b0;
`ifdef SD_RESP_BUSYWAIT_EN
        w_r1b_nxt     = r_r1b;
`endif

        unique case (r_state)
            StIdle: begin
                if (START) begin
                    w_long_nxt    = LONG;
`ifdef SD_RESP_BUSYWAIT_EN
                    w_r1b_nxt     = R1B;
`endif
                    w_r7_nxt      = '0;
                    w_timeout_nxt = 1'b0;
                    w_r1_nxt      = 8'hFF;
                    w_cnt_nxt     = '0;
                    w_phase_nxt   = PhR1;
                    w_state_nxt   = StPoll;
                end
            end
            StPoll: begin
                if (POLL_ACK) begin
                    w_state_nxt = StWaitRx;
                end
            end
            StWaitRx: begin
                if (RX_STB) begin
                    w_rx_ack_nxt = 1'b1;
                    w_state_nxt  = StPoll;
                    case (r_phase)
                        PhR1: begin
                            if (RX_DATA[7]) begin
                                // Compare before increment: the counter never wraps.
                                if (r_cnt == CW'(NCR_MAX - 1)) begin
                                    w_timeout_nxt = 1'b1;
                                    w_state_nxt   = StFin;
                                end
                                w_cnt_nxt = r_cnt + 1'b1;
                            end else begin
                                w_r1_nxt  = RX_DATA;
                                w_cnt_nxt = '0;
                                if (r_long) begin
                                    w_phase_nxt = PhData;
`ifdef SD_RESP_BUSYWAIT_EN
                                end else if (r_r1b) begin
                                    w_phase_nxt = PhBusy;
`endif
                                end else begin
                                    w_state_nxt = StFin;
                                end
                            end
                        end
                        PhData: begin
                            w_r7_nxt  = {r_r7[23:0], RX_DATA};
                            w_cnt_nxt = r_cnt + 1'b1;
                            if (r_cnt == CW'(3)) begin
                                w_state_nxt = StFin;
                            end
                        end
`ifdef SD_RESP_BUSYWAIT_EN
                        PhBusy: begin
                            if (RX_DATA != 8'h00) begin
                                w_state_nxt = StFin;
                            end else begin
                                if (r_cnt == CW'(BUSY_MAX - 1)) begin
                                    w_timeout_nxt = 1'b1;
                                    w_state_nxt   = StFin;
                                end
                                w_cnt_nxt = r_cnt + 1'b1;
                            end
                        end
`endif
                        default: begin
                            w_state_nxt = StFin;
                        end
                    endcase
                end
            end
            StFin: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign POLL_STB  = (r_state == StPoll);
    assign POLL_DATA = 8'hFF;
    assign RX_ACK    = r_rx_ack;
    assign BUSY      = (r_state == StPoll) || (r_state == StWaitRx);
    assign DONE      = (r_state == StFin);
    assign TIMEOUT   = r_timeout;
    assign R1        = r_r1;
    assign R7        = r_r7;

endmodule
